normalizer_seq: RTL

Iterative 32-bit normalizer: the inverse of the barrel shifter in the ALU datapath. Given a word, it finds the left-shift amount that normalizes it (leading one at bit 31 for unsigned; first non-sign bit at bit 30 for signed) and returns both the amount and the normalized word. One binary-search stage (16, 8, 4, 2, 1) is resolved per clock, behind a valid/ready handshake on both sides. It feeds the `sa` port of the shifter and the FP-style normalize path.

---
 rtl/normalizer_seq_pkg.sv | 20 ++
 rtl/normalizer_seq_norm_stage.sv | 28 ++
 rtl/normalizer_seq.sv | 85 ++++++++
 3 files changed

// File: rtl/normalizer_seq_pkg.sv
// Shared types and helpers for the iterative normalizer: FSM state encoding
// and the binary-search stage width for stage index k.
package normalizer_seq_pkg;

  localparam int DATA_W = 32;
  localparam int SA_W   = 5;
  localparam int K_W    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Stage width s = 2^k. k runs 4..0, so s runs 16..1 and fits the amount field.
  function automatic logic [SA_W-1:0] stage_width(input logic [K_W-1:0] k);
    return SA_W'(1) << k;
  endfunction

endpackage

// File: rtl/normalizer_seq_norm_stage.sv
// One conditional left shift of the binary search: shift by s=2^k when the
// top bits are redundant (zeros, or copies of the sign bit in signed mode).
module norm_stage
  import normalizer_seq_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic              mode,
  input  logic [K_W-1:0]    k,
  output logic [DATA_W-1:0] next_word,
  output logic              take
);

  localparam logic [DATA_W-1:0] ONES = '1;

  logic [SA_W-1:0]   s;
  logic [DATA_W-1:0] top_mask;
  logic [DATA_W-1:0] diff;

  assign s = stage_width(k);

  // Signed mode also inspects the bit below the window: the sign must survive the shift.
  assign top_mask = mode ? ~(ONES >> ({1'b0, s} + 6'd1)) : ~(ONES >> s);
  assign diff     = mode ? (word ^ {DATA_W{word[DATA_W-1]}}) : word;

  assign take      = ((diff & top_mask) == '0);
  assign next_word = take ? (word << s) : word;

endmodule

// File: rtl/normalizer_seq.sv
// Iterative 32-bit normalizer: resolves one binary-search stage (16,8,4,2,1)
// per clock behind valid/ready handshakes, returning shift amount and word.
module normalizer_seq
  import normalizer_seq_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_d,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_d,
  output logic [4:0]       out_sa,
  output logic             out_zero
);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  work_q;
  logic [SA_W-1:0]   amt_q;
  logic [K_W-1:0]    k_q;
  logic              zero_q;
  logic              mode_q;

  logic [DATA_W-1:0] stage_word;
  logic              stage_take;
  logic              accept;

  norm_stage u_stage (
    .word      (work_q),
    .mode      (mode_q),
    .k         (k_q),
    .next_word (stage_word),
    .take      (stage_take)
  );

  assign accept = in_valid && (state_q == IDLE);

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)   state_d = SHIFT;
      SHIFT:   if (k_q == '0)  state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      amt_q   <= '0;
      k_q     <= '0;
      zero_q  <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        work_q <= in_d;
        mode_q <= in_signed;
        zero_q <= (in_d == '0);
        amt_q  <= '0;
        k_q    <= K_W'(4);
      end else if (state_q == SHIFT) begin
        work_q <= stage_word;
        amt_q  <= amt_q + (stage_take ? stage_width(k_q) : '0);
        if (k_q != '0) k_q <= k_q - K_W'(1);
      end
    end
  end

  // Zero input runs the full search (amount saturates at 31), so results are forced here.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_d     = zero_q ? '0 : work_q;
  assign out_sa    = zero_q ? '0 : amt_q;
  assign out_zero  = zero_q;

endmodule
